// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO peripheral: register word offsets and bus data width.
package gpio_pkg;

  localparam int unsigned GPIO_DATA_W = 32;

  localparam int unsigned GPIO_OFF_OUT  = 0;
  localparam int unsigned GPIO_OFF_SET  = 1;
  localparam int unsigned GPIO_OFF_CLR  = 2;
  localparam int unsigned GPIO_OFF_TGL  = 3;
  localparam int unsigned GPIO_OFF_IN   = 4;
  localparam int unsigned GPIO_OFF_PEND = 5;
  localparam int unsigned GPIO_OFF_MASK = 6;
  localparam int unsigned GPIO_OFF_POL  = 7;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchronizer chain plus previous-sample register and per-bit edge detect.
// GPIO_FALL_EDGE_EN adds a per-bit polarity select (1 = falling edge).
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef GPIO_FALL_EDGE_EN
  input  logic [WIDTH-1:0] pol_i,
`endif
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef GPIO_FALL_EDGE_EN
  // Polarity only selects the comparison; prev_q is untouched so a POL change never fires.
  assign edge_o = (pol_i & ~sync_o & prev_q) | (~pol_i & sync_o & ~prev_q);
`else
  assign edge_o = sync_o & ~prev_q;
`endif

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO: OUT with set/clear/toggle aliases, synchronized inputs,
// W1C pending register and masked level irq. GPIO_FALL_EDGE_EN enables POL at offset 7.
module gpio_port #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio,
  output logic              irq
);
  import gpio_pkg::*;

  logic [WIDTH-1:0]       out_q, out_d;
  logic [WIDTH-1:0]       pend_q, pend_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [WIDTH-1:0]       pend_clr;
  logic [WIDTH-1:0]       in_sync, in_edge;
  logic [WIDTH-1:0]       wval;
  logic [GPIO_DATA_W-1:0] rdata_q, rdata_d;
  logic                   rvalid_q;
  logic                   irq_q;

  assign wval = wdata[WIDTH-1:0];

`ifdef GPIO_FALL_EDGE_EN
  logic [WIDTH-1:0] pol_q, pol_d;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .pol_i  (pol_q),
    .in_i   (gpio_in),
    .sync_o (in_sync),
    .edge_o (in_edge)
  );
`else
  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .in_i   (gpio_in),
    .sync_o (in_sync),
    .edge_o (in_edge)
  );
`endif

  // Write decode
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    pend_clr = '0;
`ifdef GPIO_FALL_EDGE_EN
    pol_d    = pol_q;
`endif
    if (we) begin
      case (addr)
        ADDR_W'(GPIO_OFF_OUT):  out_d    = wval;
        ADDR_W'(GPIO_OFF_SET):  out_d    = out_q | wval;
        ADDR_W'(GPIO_OFF_CLR):  out_d    = out_q & ~wval;
        ADDR_W'(GPIO_OFF_TGL):  out_d    = out_q ^ wval;
        ADDR_W'(GPIO_OFF_PEND): pend_clr = wval;
        ADDR_W'(GPIO_OFF_MASK): mask_d   = wval;
`ifdef GPIO_FALL_EDGE_EN
        ADDR_W'(GPIO_OFF_POL):  pol_d    = wval;
`endif
        default: ;
      endcase
    end
    // A fresh edge overrides a same-cycle write-1-to-clear of that bit.
    pend_d = (pend_q & ~pend_clr) | in_edge;
  end

  // Read mux sees pre-write register values, giving read-before-write ordering.
  always_comb begin
    rdata_d = '0;
    case (addr)
      ADDR_W'(GPIO_OFF_OUT),
      ADDR_W'(GPIO_OFF_SET),
      ADDR_W'(GPIO_OFF_CLR),
      ADDR_W'(GPIO_OFF_TGL):  rdata_d[WIDTH-1:0] = out_q;
      ADDR_W'(GPIO_OFF_IN):   rdata_d[WIDTH-1:0] = in_sync;
      ADDR_W'(GPIO_OFF_PEND): rdata_d[WIDTH-1:0] = pend_q;
      ADDR_W'(GPIO_OFF_MASK): rdata_d[WIDTH-1:0] = mask_q;
`ifdef GPIO_FALL_EDGE_EN
      ADDR_W'(GPIO_OFF_POL):  rdata_d[WIDTH-1:0] = pol_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q    <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      rvalid_q <= re;
      irq_q    <= |(pend_q & mask_q);
      if (re) rdata_q <= rdata_d;
    end
  end

`ifdef GPIO_FALL_EDGE_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pol_q <= '0;
    else       pol_q <= pol_d;
  end
`endif

  assign gpio   = out_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: vector table for register access, scoreboard for reads,
// hand-written sequences for edge/irq/reset timing. Honors GPIO_FALL_EDGE_EN.
module tb_gpio_port;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio;
  logic        irq;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] exp_q[$];

  gpio_port #(
    .WIDTH       (32),
    .SYNC_STAGES (2),
    .ADDR_W      (3)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .addr    (addr),
    .we      (we),
    .re      (re),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .gpio_in (gpio_in),
    .gpio    (gpio),
    .irq     (irq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          rd;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] e);
    addr = a; re = 1'b1;
    exp_q.push_back(e);
    tick(1);
    re = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (!Reset && rvalid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rvalid_unexpected: got rdata %h with no read outstanding", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] rsvd_exp;
`ifdef GPIO_FALL_EDGE_EN
    rsvd_exp = 32'h0000FFFF;
`else
    rsvd_exp = 32'h0;
`endif
    vecs[0]  = '{1'b0, 3'd0, 32'h000000F0, 32'h000000F0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0000000F, 32'h000000FF};
    vecs[2]  = '{1'b1, 3'd1, 32'h0,        32'h000000FF};
    vecs[3]  = '{1'b0, 3'd2, 32'h000000F0, 32'h0000000F};
    vecs[4]  = '{1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFF0};
    vecs[5]  = '{1'b1, 3'd0, 32'h0,        32'hFFFFFFF0};
    vecs[6]  = '{1'b0, 3'd6, 32'h00000005, 32'hFFFFFFF0};
    vecs[7]  = '{1'b1, 3'd6, 32'h0,        32'h00000005};
    vecs[8]  = '{1'b0, 3'd0, 32'h12345678, 32'h12345678};
    vecs[9]  = '{1'b0, 3'd7, 32'h0000FFFF, 32'h12345678};
    vecs[10] = '{1'b1, 3'd7, 32'h0,        rsvd_exp};
    vecs[11] = '{1'b0, 3'd7, 32'h0,        32'h12345678};
    vecs[12] = '{1'b1, 3'd4, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 3'd6, 32'h0,        32'h12345678};

    #1;
    check("reset_gpio", gpio, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    tick(2);
    Reset = 1'b0;
    tick(1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rd) begin
        do_read(vecs[i].a, vecs[i].exp);
      end else begin
        do_write(vecs[i].a, vecs[i].d);
        check($sformatf("vec%0d_gpio", i), gpio, vecs[i].exp);
      end
    end

    // Read timing: rvalid for exactly one cycle, rdata held afterwards.
    do_read(3'd0, 32'h12345678);
    check("rvalid_high", {31'h0, rvalid}, 32'h1);
    tick(1);
    check("rvalid_drop", {31'h0, rvalid}, 32'h0);
    check("rdata_hold", rdata, 32'h12345678);

    // Simultaneous write and read: read returns the old value.
    addr = 3'd0; wdata = 32'hAAAA5555; we = 1'b1; re = 1'b1;
    exp_q.push_back(32'h12345678);
    tick(1);
    we = 1'b0; re = 1'b0;
    check("rw_gpio", gpio, 32'hAAAA5555);
    tick(1);

    // Rising edge -> PEND after SYNC_STAGES+1 edges, irq one edge later.
    do_write(3'd6, 32'h1);
    gpio_in[0] = 1'b1;
    tick(3);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    do_read(3'd5, 32'h1);
    check("irq_set", {31'h0, irq}, 32'h1);
    do_write(3'd5, 32'h1);
    tick(1);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    do_read(3'd5, 32'h0);

    // Edge coincident with W1C of the same bit: bit stays set.
    gpio_in[0] = 1'b0;
    tick(4);
    gpio_in[0] = 1'b1;
    tick(2);
    do_write(3'd5, 32'h1);
    do_read(3'd5, 32'h1);
    check("irq_after_coincident", {31'h0, irq}, 32'h1);

    // Clearing MASK drops irq without touching PEND.
    do_write(3'd6, 32'h0);
    tick(1);
    check("irq_mask_clr", {31'h0, irq}, 32'h0);
    do_read(3'd5, 32'h1);
    do_write(3'd5, 32'h1);

`ifdef GPIO_FALL_EDGE_EN
    do_write(3'd7, 32'h2);
    gpio_in[1] = 1'b1;
    tick(5);
    do_read(3'd5, 32'h0);
    gpio_in[1] = 1'b0;
    tick(4);
    do_read(3'd5, 32'h2);
    do_write(3'd5, 32'h2);
    gpio_in[1] = 1'b1;
    tick(4);
    do_read(3'd5, 32'h0);
    do_write(3'd7, 32'h0);
`endif

    // Asynchronous reset mid-run.
    gpio_in = '0;
    tick(4);
    do_write(3'd0, 32'hDEADBEEF);
    do_write(3'd6, 32'h1);
    gpio_in[0] = 1'b1;
    tick(4);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    do_read(3'd0, 32'hDEADBEEF);
    tick(1);
    #2;
    Reset = 1'b1;
    gpio_in = '0;
    #1;
    check("async_gpio", gpio, 32'h0);
    check("async_rdata", rdata, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    tick(2);
    Reset = 1'b0;
    tick(1);
    do_read(3'd0, 32'h0);
    do_read(3'd6, 32'h0);
    do_read(3'd5, 32'h0);
    tick(2);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
